// File: rtl/diffusion_seq_if.sv
// Handshake bundle for diffusion_seq: upstream valid/ready with the input state,
// and downstream valid/ready with the diffused state.
//   slave  : view of the diffusion block (consumes state_i, produces state_o)
//   master : view of the surrounding datapath / testbench
// Optional: bypass_i exists only when DIFFUSION_BYPASS_EN is defined.
interface diffusion_seq_if #(
    parameter int unsigned WIDTH = 64
);
    logic                  valid_i;
    logic                  ready_o;
    logic [4:0][WIDTH-1:0] state_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [4:0][WIDTH-1:0] state_o;
`ifdef DIFFUSION_BYPASS_EN
    logic                  bypass_i;

    modport slave (
        input  valid_i, state_i, ready_i, bypass_i,
        output ready_o, valid_o, state_o
    );
    modport master (
        output valid_i, state_i, ready_i, bypass_i,
        input  ready_o, valid_o, state_o
    );
`else
    modport slave (
        input  valid_i, state_i, ready_i,
        output ready_o, valid_o, state_o
    );
    modport master (
        output valid_i, state_i, ready_i,
        input  ready_o, valid_o, state_o
    );
`endif
endinterface

// File: rtl/diffusion_seq.sv
// diffusion_seq: registered, handshaked Ascon linear diffusion layer p_L.
// Each lane becomes x ^ ror(x,a) ^ ror(x,b); all five lanes per cycle (LPC=5)
// or one lane per cycle (LPC=1).
// Ports:
//   clock_i  : rising-edge clock
//   resetb_i : asynchronous active-low reset
//   bus      : diffusion_seq_if.slave (valid_i/ready_o/state_i in,
//              valid_o/ready_i/state_o out, bypass_i when enabled)
// Optional feature macro: DIFFUSION_BYPASS_EN (adds bypass_i; a latched 1
// passes the state through unmodified with unchanged timing).
module diffusion_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LPC   = 5
) (
    input  logic           clock_i,
    input  logic           resetb_i,
    diffusion_seq_if.slave bus
);
    localparam int unsigned NLANES = 5;
    localparam int unsigned CNT_W  = 3;

    typedef logic [NLANES-1:0][WIDTH-1:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    // Elaboration-time parameter legality
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("diffusion_seq: WIDTH must be in 8..64");
    end
    if (LPC != 1 && LPC != 5) begin : g_bad_lpc
        $error("diffusion_seq: LPC must be 1 or 5");
    end

    // Right-rotate; amount taken mod WIDTH, a zero amount returns x
    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input int unsigned amt);
        int unsigned r;
        r = amt % WIDTH;
        return (x >> r) | (x << (WIDTH - r));
    endfunction

    function automatic int unsigned rot_a(input logic [CNT_W-1:0] lane);
        case (lane)
            3'd0:    return 19;
            3'd1:    return 61;
            3'd2:    return 1;
            3'd3:    return 10;
            3'd4:    return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned rot_b(input logic [CNT_W-1:0] lane);
        case (lane)
            3'd0:    return 28;
            3'd1:    return 39;
            3'd2:    return 6;
            3'd3:    return 17;
            3'd4:    return 41;
            default: return 0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] diffuse_lane(input logic [CNT_W-1:0] lane,
                                                      input logic [WIDTH-1:0] x);
        return x ^ ror(x, rot_a(lane)) ^ ror(x, rot_b(lane));
    endfunction

    fsm_t             fsm_q,    fsm_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    state_t           work_q,   work_d;
    state_t           out_q,    out_d;
    logic             valid_q,  valid_d;
    logic             bypass_q, bypass_d;
    logic             bypass_in;
    logic             ready_c;
    logic             accept_c;

`ifdef DIFFUSION_BYPASS_EN
    assign bypass_in = bus.bypass_i;
`else
    assign bypass_in = 1'b0;
`endif

    // Ready depends only on FSM state and downstream ready, never on valid_i
    assign ready_c  = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.ready_i);
    assign accept_c = bus.valid_i && ready_c;

    assign bus.ready_o = ready_c;
    assign bus.valid_o = valid_q;
    assign bus.state_o = out_q;

    // Next-state: lane sequencing in RUN, release in DONE, then capture on accept
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        out_d    = out_q;
        valid_d  = valid_q;
        bypass_d = bypass_q;

        case (fsm_q)
            RUN: begin
                out_d[cnt_q] = bypass_q ? work_q[cnt_q] : diffuse_lane(cnt_q, work_q[cnt_q]);
                if (cnt_q == CNT_W'(NLANES - 1)) begin
                    fsm_d   = DONE;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    fsm_d   = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept overrides the DONE release so back-to-back keeps streaming
        if (accept_c) begin
            work_d   = bus.state_i;
            bypass_d = bypass_in;
            if (LPC == 5) begin
                for (int i = 0; i < int'(NLANES); i++) begin
                    out_d[i] = bypass_in ? bus.state_i[i]
                                         : diffuse_lane(CNT_W'(i), bus.state_i[i]);
                end
                fsm_d   = DONE;
                valid_d = 1'b1;
            end else begin
                fsm_d   = RUN;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            bypass_q <= bypass_d;
        end
    end
endmodule

// File: tb/tb_diffusion_seq.sv
// Testbench for diffusion_seq: one LPC=5 and one LPC=1 instance (WIDTH=64),
// scenario tasks with inline checks plus a scoreboard of modelled results per
// instance, compared whenever an output transfer happens.
module tb_diffusion_seq;
    localparam int unsigned W = 64;
    typedef logic [4:0][W-1:0] st_t;

    logic clk = 1'b0;
    logic rst5_n;
    logic rst1_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    diffusion_seq_if #(.WIDTH(W)) b5 ();
    diffusion_seq_if #(.WIDTH(W)) b1 ();

    diffusion_seq #(.WIDTH(W), .LPC(5)) u_dut5 (.clock_i(clk), .resetb_i(rst5_n), .bus(b5));
    diffusion_seq #(.WIDTH(W), .LPC(1)) u_dut1 (.clock_i(clk), .resetb_i(rst1_n), .bus(b1));

    // Independent reference: rotation via a doubled word
    function automatic logic [W-1:0] ror_m(input logic [W-1:0] x, input int unsigned r);
        logic [2*W-1:0] d;
        d = {x, x};
        return d[(r % W) +: W];
    endfunction

    function automatic st_t model(input st_t s, input logic bp);
        int unsigned ra [5];
        int unsigned rb [5];
        st_t         o;
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        for (int i = 0; i < 5; i++) begin
            o[i] = bp ? s[i] : (s[i] ^ ror_m(s[i], ra[i]) ^ ror_m(s[i], rb[i]));
        end
        return o;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    st_t q5[$];
    st_t q1[$];
    st_t e5;
    st_t e1;
    logic bp5;
    logic bp1;

`ifdef DIFFUSION_BYPASS_EN
    assign bp5 = b5.bypass_i;
    assign bp1 = b1.bypass_i;
`else
    assign bp5 = 1'b0;
    assign bp1 = 1'b0;
`endif

    // Scoreboards: pop on transfer, push on accept (inputs are stable at negedge)
    always @(negedge clk) begin
        if (!rst5_n) q5.delete();
        else begin
            if (b5.valid_o && b5.ready_i) begin
                checks++;
                if (q5.size() == 0) begin
                    errors++;
                    $display("FAIL sb5_unexpected got=%h", b5.state_o);
                end else begin
                    e5 = q5.pop_front();
                    if (b5.state_o !== e5) begin
                        errors++;
                        $display("FAIL sb5_data got=%h exp=%h", b5.state_o, e5);
                    end
                end
            end
            if (b5.valid_i && b5.ready_o) q5.push_back(model(b5.state_i, bp5));
        end
    end

    always @(negedge clk) begin
        if (!rst1_n) q1.delete();
        else begin
            if (b1.valid_o && b1.ready_i) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_unexpected got=%h", b1.state_o);
                end else begin
                    e1 = q1.pop_front();
                    if (b1.state_o !== e1) begin
                        errors++;
                        $display("FAIL sb1_data got=%h exp=%h", b1.state_o, e1);
                    end
                end
            end
            if (b1.valid_i && b1.ready_o) q1.push_back(model(b1.state_i, bp1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst5_n = 1'b0;
        rst1_n = 1'b0;
        b5.valid_i = 1'b0; b5.ready_i = 1'b0; b5.state_i = '0;
        b1.valid_i = 1'b0; b1.ready_i = 1'b0; b1.state_i = '0;
`ifdef DIFFUSION_BYPASS_EN
        b5.bypass_i = 1'b0;
        b1.bypass_i = 1'b0;
`endif
        #1;
        checks++; if (b5.valid_o !== 1'b0 || b5.ready_o !== 1'b1 || b5.state_o !== '0) begin
            errors++; $display("FAIL rst5 valid=%b ready=%b state=%h exp 0/1/0", b5.valid_o, b5.ready_o, b5.state_o); end
        checks++; if (b1.valid_o !== 1'b0 || b1.ready_o !== 1'b1 || b1.state_o !== '0) begin
            errors++; $display("FAIL rst1 valid=%b ready=%b state=%h exp 0/1/0", b1.valid_o, b1.ready_o, b1.state_o); end
        cyc(); cyc();
        rst5_n = 1'b1;
        rst1_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            checks++; if (b5.valid_o !== 1'b0 || b5.ready_o !== 1'b1 || b5.state_o !== '0) begin
                errors++; $display("FAIL idle5 cyc=%0d valid=%b ready=%b state=%h", n, b5.valid_o, b5.ready_o, b5.state_o); end
            checks++; if (b1.valid_o !== 1'b0 || b1.ready_o !== 1'b1 || b1.state_o !== '0) begin
                errors++; $display("FAIL idle1 cyc=%0d valid=%b ready=%b state=%h", n, b1.valid_o, b1.ready_o, b1.state_o); end
        end
    endtask

    task automatic test_impulse5();
        st_t s;
        st_t ex;
        s = '0; s[0] = 64'd1; s[2] = 64'd1;
        ex = '0; ex[0] = 64'h0000201000000001; ex[2] = 64'h8400000000000001;
        b5.state_i = s; b5.valid_i = 1'b1; b5.ready_i = 1'b0;
        cyc();
        b5.valid_i = 1'b0;
        checks++; if (b5.valid_o !== 1'b1 || b5.state_o !== ex) begin
            errors++; $display("FAIL imp5 valid=%b got=%h exp=%h", b5.valid_o, b5.state_o, ex); end
        b5.ready_i = 1'b1;
        cyc();
        checks++; if (b5.valid_o !== 1'b0) begin
            errors++; $display("FAIL imp5_release valid=%b exp 0", b5.valid_o); end
        // All-ones is a fixed point of x ^ ror ^ ror
        b5.state_i = '1; b5.valid_i = 1'b1; b5.ready_i = 1'b0;
        cyc();
        b5.valid_i = 1'b0;
        ex = '1;
        checks++; if (b5.valid_o !== 1'b1 || b5.state_o !== ex) begin
            errors++; $display("FAIL ones5 valid=%b got=%h exp=%h", b5.valid_o, b5.state_o, ex); end
        b5.ready_i = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back();
        st_t last;
        last = '0;
        b5.ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b5.state_i = rand_state();
            last = b5.state_i;
            b5.valid_i = 1'b1;
            cyc();
            checks++; if (b5.valid_o !== 1'b1) begin
                errors++; $display("FAIL b2b_valid k=%0d got=%b exp 1", k, b5.valid_o); end
        end
        // Stall: result must hold and no new accept is possible
        b5.ready_i = 1'b0;
        b5.state_i = rand_state();
        #1;
        for (int n = 0; n < 3; n++) begin
            checks++; if (b5.ready_o !== 1'b0 || b5.valid_o !== 1'b1 || b5.state_o !== model(last, 1'b0)) begin
                errors++; $display("FAIL b2b_hold n=%0d ready=%b valid=%b got=%h exp=%h",
                                   n, b5.ready_o, b5.valid_o, b5.state_o, model(last, 1'b0)); end
            cyc();
        end
        b5.valid_i = 1'b0;
        b5.ready_i = 1'b1;
        cyc();
        checks++; if (b5.valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drain valid=%b exp 0", b5.valid_o); end
    endtask

    task automatic test_lpc1();
        st_t s;
        st_t ex;
        s = '0; s[0] = 64'd1; s[2] = 64'd1;
        ex = '0; ex[0] = 64'h0000201000000001; ex[2] = 64'h8400000000000001;
        b1.state_i = s; b1.valid_i = 1'b1; b1.ready_i = 1'b0;
        cyc();
        b1.valid_i = 1'b0;
        for (int n = 0; n < 5; n++) begin
            checks++; if (b1.valid_o !== 1'b0 || b1.ready_o !== 1'b0) begin
                errors++; $display("FAIL lpc1_run n=%0d valid=%b ready=%b exp 0/0", n, b1.valid_o, b1.ready_o); end
            // Stray valid during RUN must be ignored
            if (n == 2) begin
                b1.state_i = '1;
                b1.valid_i = 1'b1;
            end else begin
                b1.valid_i = 1'b0;
            end
            cyc();
        end
        b1.valid_i = 1'b0;
        checks++; if (b1.valid_o !== 1'b1 || b1.state_o !== ex) begin
            errors++; $display("FAIL lpc1_imp valid=%b got=%h exp=%h", b1.valid_o, b1.state_o, ex); end
        b1.ready_i = 1'b1;
        cyc();
        checks++; if (b1.valid_o !== 1'b0 || b1.ready_o !== 1'b1) begin
            errors++; $display("FAIL lpc1_release valid=%b ready=%b exp 0/1", b1.valid_o, b1.ready_o); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        b1.state_i = rand_state(); b1.valid_i = 1'b1; b1.ready_i = 1'b0;
        cyc();
        b1.valid_i = 1'b0;
        cyc(); cyc();
        // Now at cnt=2
        rst1_n = 1'b0;
        #1;
        checks++; if (b1.state_o !== '0 || b1.valid_o !== 1'b0 || b1.ready_o !== 1'b1) begin
            errors++; $display("FAIL midrst state=%h valid=%b ready=%b exp 0/0/1", b1.state_o, b1.valid_o, b1.ready_o); end
        cyc();
        rst1_n = 1'b1;
        b1.state_i = rand_state(); b1.valid_i = 1'b1; b1.ready_i = 1'b1;
        cyc();
        b1.valid_i = 1'b0;
        n = 1;
        while (b1.valid_o !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++; if (b1.valid_o !== 1'b1 || n != 6) begin
            errors++; $display("FAIL postrst_latency valid=%b cycles=%0d exp 1/6", b1.valid_o, n); end
        cyc();
    endtask

`ifdef DIFFUSION_BYPASS_EN
    task automatic test_bypass();
        st_t s;
        s = '0; s[0] = 64'hDEADBEEF00000001;
        b5.state_i = s; b5.bypass_i = 1'b1; b5.valid_i = 1'b1; b5.ready_i = 1'b0;
        cyc();
        b5.valid_i = 1'b0; b5.bypass_i = 1'b0;
        checks++; if (b5.valid_o !== 1'b1 || b5.state_o[0] !== 64'hDEADBEEF00000001) begin
            errors++; $display("FAIL byp5 valid=%b lane0=%h exp 1/deadbeef00000001", b5.valid_o, b5.state_o[0]); end
        b5.ready_i = 1'b1;
        cyc();
        b5.valid_i = 1'b1;
        cyc();
        b5.valid_i = 1'b0;
        cyc();
        b1.state_i = s; b1.bypass_i = 1'b1; b1.valid_i = 1'b1; b1.ready_i = 1'b0;
        cyc();
        b1.valid_i = 1'b0; b1.bypass_i = 1'b0;
        repeat (5) cyc();
        checks++; if (b1.valid_o !== 1'b1 || b1.state_o[0] !== 64'hDEADBEEF00000001) begin
            errors++; $display("FAIL byp1 valid=%b lane0=%h exp 1/deadbeef00000001", b1.valid_o, b1.state_o[0]); end
        b1.ready_i = 1'b1;
        cyc();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse5();
        test_back_to_back();
        test_lpc1();
        test_reset_mid_run();
`ifdef DIFFUSION_BYPASS_EN
        test_bypass();
`endif
        cyc(); cyc();
        checks++; if (q5.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL sb_leftover q5=%0d q1=%0d exp 0/0", q5.size(), q1.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/diffusion_seq.md
# diffusion_seq

Parametrised, handshaked successor to the combinational Ascon linear diffusion layer p_L. It registers a 5-lane state and applies x ^ ror(x,a) ^ ror(x,b) per lane, either all lanes in one cycle or one lane per cycle for area-constrained builds. It sits between the substitution layer and the round register of the permutation datapath, behind valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 64, lane width in bits. Legal range is 8..64. Each rotation amount is taken mod WIDTH. WIDTH=64 is exact Ascon.
- LPC, 5, lanes processed per cycle. Only 1 and 5 are legal. Any other value is a elaboration error ($error).

Ports:
- clock_i, in, 1, sole clock. Everything is rising-edge.
- resetb_i, in, 1, asynchronous active-low reset.
- valid_i, in, 1, input state is offered.
- ready_o, out, 1, block accepts input this cycle.
- state_i, in, 5xWIDTH, input state (type_state layout, lanes 0..4).
- valid_o, out, 1, state_o holds a finished result.
- ready_i, in, 1, downstream consumes the result.
- state_o, out, 5xWIDTH, registered diffused state.
- bypass_i, in, 1, present only with DIFFUSION_BYPASS_EN. Sampled on accept.

## Operation
Right-rotation pairs (a,b) per lane:
- lane 0: (19,28)
- lane 1: (61,39)
- lane 2: (1,6)
- lane 3: (10,17)
- lane 4: (7,41)

Handshake rules:
- Accept occurs when valid_i && ready_o. The input is sampled into an internal work register.
- ready_o = (fsm==IDLE) || (fsm==DONE && ready_i). It is a combinational function of state and ready_i only, never of valid_i.
- Output transfer occurs when valid_o && ready_i.
- state_o and valid_o are stable while valid_o=1 && ready_i=0.

FSM states are IDLE, RUN and DONE. RUN exists only when LPC=1.
- LPC=5:
  - IDLE -accept-> DONE. All 5 lanes are diffused into state_o at the accept edge.
  - DONE -transfer without new accept-> IDLE.
  - DONE -transfer and accept in the same cycle-> DONE, with the new result. This gives back-to-back throughput of 1 state per cycle.
- LPC=1:
  - IDLE -accept-> RUN with lane counter cnt=0.
  - In RUN, each cycle: state_o[cnt] <= diffuse(work[cnt]), then cnt++.
  - After cnt=4 is written: RUN -> DONE, valid_o=1.
  - DONE follows the same transfer and accept rules as LPC=5. A same-cycle accept goes to RUN with cnt=0 and valid_o=0.
- During RUN, lanes not yet written keep their previous values. valid_o=0 throughout RUN.
- valid_i is ignored in RUN.
- cnt is 3 bits and never exceeds 4. It resets to 0 on leaving RUN.

## Timing
- Reset (asynchronous, resetb_i=0):
  - fsm=IDLE, cnt=0, valid_o=0.
  - state_o = all zeros; the work register is cleared.
  - ready_o=1 as soon as reset asserts.
- Reset mid-RUN or in DONE aborts the transaction with no output. Downstream sees only valid_o dropping.
- Latency from the accept edge to valid_o=1:
  - LPC=5: 1 cycle.
  - LPC=1: 6 cycles (1 capture cycle + 5 lane cycles).
- Throughput:
  - LPC=5: 1 state per cycle while ready_i=1.
  - LPC=1: 1 state per 6 cycles.
- A held result never self-overwrites. A new accept in DONE requires ready_i=1 in the same cycle.

## Configuration
- DIFFUSION_BYPASS_EN defined:
  - Port bypass_i exists and is latched at accept.
  - When the latched value is 1, every lane is written unmodified (state_o = state_i).
  - Latency, FSM sequence and handshakes are identical to the non-bypass case.
- DIFFUSION_BYPASS_EN undefined: the port is absent and diffusion is always applied.

## Test plan
- Reset then idle: expect valid_o=0, ready_o=1, state_o=0. Deassert resetb_i for 3 cycles with valid_i=0: expect no change.
- LPC=5, WIDTH=64, impulse input:
  - Input: lane0=1, lane2=1, other lanes 0.
  - Expected 1 cycle later: lane0=0x0000201000000001, lane2=0x8400000000000001, lanes 1/3/4=0.
  - Also check all-ones input gives all-ones output.
- LPC=5, back-to-back stream: 4 states with ready_i=1 -> 4 consecutive valid_o cycles in order. Then ready_i=0 for 3 cycles -> state_o held and ready_o=0.
- LPC=1, same impulse input:
  - valid_o rises exactly 6 cycles after accept with the same values as the LPC=5 case.
  - ready_o=0 throughout RUN.
  - A valid_i pulse during RUN is ignored.
- Reset mid-RUN: assert resetb_i=0 at cnt=2 -> immediately state_o=0 and valid_o=0. Next transaction completes correctly.
- DIFFUSION_BYPASS_EN with bypass_i=1 and lane0=0xDEADBEEF00000001 -> state_o lane0=0xDEADBEEF00000001 with normal latency. With bypass_i=0 the result is normal diffusion.
